// File: rtl/card_pkg.sv
// card_pkg: card codes, board segment patterns, reader FSM states and score reduction
package card_pkg;
  typedef logic [3:0] card_t;
  localparam card_t CARD_BLANK = 4'd0;
  localparam card_t CARD_A     = 4'd1;
  localparam card_t CARD_10    = 4'd10;
  localparam card_t CARD_J     = 4'd11;
  localparam card_t CARD_Q     = 4'd12;
  localparam card_t CARD_K     = 4'd13;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_10    = 7'b1000000;
  localparam logic [6:0] SEG_J     = 7'b1100001;
  localparam logic [6:0] SEG_Q     = 7'b0011000;
  localparam logic [6:0] SEG_K     = 7'b0001001;
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_SCORE} state_t;
  // three cards sum to at most 27, so two conditional subtractions give mod 10
  function automatic logic [3:0] mod10(input logic [4:0] s);
    logic [4:0] t;
    t = s >= 5'd20 ? s - 5'd20 : s;
    t = t >= 5'd10 ? t - 5'd10 : t;
    return t[3:0];
  endfunction
endpackage

// File: rtl/seg7_to_card.sv
// seg7_to_card: combinational 7-segment pattern to card code, point value and recognised flag
module seg7_to_card
  import card_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1
) (
  input  logic [6:0] seg_i,
  output card_t      code_o,
  output logic [3:0] points_o,
  output logic       ok_o
);
  logic [6:0] pat;
  assign pat = SEG_ACTIVE_LOW ? seg_i : ~seg_i;
  always_comb begin
    code_o = CARD_BLANK;
    ok_o   = 1'b1;
    case (pat)
      SEG_BLANK: code_o = CARD_BLANK;
      SEG_A:     code_o = CARD_A;
      SEG_2:     code_o = 4'd2;
      SEG_3:     code_o = 4'd3;
      SEG_4:     code_o = 4'd4;
      SEG_5:     code_o = 4'd5;
      SEG_6:     code_o = 4'd6;
      SEG_7:     code_o = 4'd7;
      SEG_8:     code_o = 4'd8;
      SEG_9:     code_o = 4'd9;
      SEG_10:    code_o = CARD_10;
      SEG_J:     code_o = CARD_J;
      SEG_Q:     code_o = CARD_Q;
      SEG_K:     code_o = CARD_K;
      default:   ok_o   = 1'b0;
    endcase
  end
  assign points_o = (code_o != CARD_BLANK && code_o <= 4'd9) ? code_o : 4'd0;
endmodule

// File: rtl/seg7_hand_reader.sv
// seg7_hand_reader: snapshots six HEX digits, decodes them one per cycle and recomputes both baccarat scores
module seg7_hand_reader
  import card_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1
) (
  input  logic       CLOCK_50,
  input  logic       resetb,
  input  logic [6:0] HEX0,
  input  logic [6:0] HEX1,
  input  logic [6:0] HEX2,
  input  logic [6:0] HEX3,
  input  logic [6:0] HEX4,
  input  logic [6:0] HEX5,
  input  logic       start,
  output logic       busy,
  output logic       valid,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic       err,
  output logic [2:0] err_digit
);
  state_t     state_q;
  logic [6:0] snap_q [6];
  card_t      card_q [6];
  logic [2:0] idx_q, err_digit_q;
  logic [4:0] pacc_q, dacc_q;
  logic [3:0] pscore_q, dscore_q;
  logic       busy_q, valid_q, err_q;
  logic [6:0] seg_d;
  card_t      code_d;
  logic [3:0] pts_d;
  logic       ok_d;
  assign seg_d = snap_q[idx_q];
  seg7_to_card #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec (
    .seg_i   (seg_d),
    .code_o  (code_d),
    .points_o(pts_d),
    .ok_o    (ok_d)
  );
  always_ff @(posedge CLOCK_50 or negedge resetb) begin
    if (!resetb) begin
      state_q     <= S_IDLE;
      snap_q      <= '{default: '0};
      card_q      <= '{default: '0};
      idx_q       <= '0;
      pacc_q      <= '0;
      dacc_q      <= '0;
      pscore_q    <= '0;
      dscore_q    <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      err_digit_q <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          snap_q      <= '{HEX0, HEX1, HEX2, HEX3, HEX4, HEX5};
          idx_q       <= '0;
          pacc_q      <= '0;
          dacc_q      <= '0;
          err_q       <= 1'b0;
          err_digit_q <= '0;
          busy_q      <= 1'b1;
          state_q     <= S_SCAN;
        end
        S_SCAN: begin
          card_q[idx_q] <= code_d;
          if (idx_q < 3'd3) pacc_q <= pacc_q + {1'b0, pts_d};
          else dacc_q <= dacc_q + {1'b0, pts_d};
          if (!ok_d && !err_q) begin
            err_q       <= 1'b1;
            err_digit_q <= idx_q;
          end
          idx_q   <= idx_q + 3'd1;
          state_q <= idx_q == 3'd5 ? S_SCORE : S_SCAN;
        end
        S_SCORE: begin
          pscore_q <= mod10(pacc_q);
          dscore_q <= mod10(dacc_q);
          valid_q  <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign busy      = busy_q;
  assign valid     = valid_q;
  assign pcard1    = card_q[0];
  assign pcard2    = card_q[1];
  assign pcard3    = card_q[2];
  assign dcard1    = card_q[3];
  assign dcard2    = card_q[4];
  assign dcard3    = card_q[5];
  assign pscore    = pscore_q;
  assign dscore    = dscore_q;
  assign err       = err_q;
  assign err_digit = err_digit_q;
endmodule

// File: tb/tb_seg7_hand_reader.sv
// tb_seg7_hand_reader: scoreboard bench; expected hands come from a table-lookup model of the card rules
module tb_seg7_hand_reader;
  logic       clk = 1'b0, resetb = 1'b0, start = 1'b0;
  logic [6:0] hex [6];
  logic       busy, valid, err;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, pscore, dscore;
  logic [2:0] err_digit;
  typedef struct packed {
    logic [23:0] card;
    logic [3:0]  ps;
    logic [3:0]  ds;
    logic        e;
    logic [2:0]  ed;
    logic [31:0] due;
  } exp_t;
  exp_t q[$];
  logic [6:0] tbl [14] = '{7'b1111111, 7'b0001000, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                           7'b1000000, 7'b1100001, 7'b0011000, 7'b0001001};
  int checks = 0, errors = 0, cyc = 0, vcount = 0;

  seg7_hand_reader dut (
    .CLOCK_50(clk), .resetb(resetb),
    .HEX0(hex[0]), .HEX1(hex[1]), .HEX2(hex[2]), .HEX3(hex[3]), .HEX4(hex[4]), .HEX5(hex[5]),
    .start(start), .busy(busy), .valid(valid),
    .pcard1(pcard1), .pcard2(pcard2), .pcard3(pcard3),
    .dcard1(dcard1), .dcard2(dcard2), .dcard3(dcard3),
    .pscore(pscore), .dscore(dscore), .err(err), .err_digit(err_digit)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [6:0] h [6], input int due);
    exp_t x;
    int ps = 0, ds = 0;
    x = '0;
    x.due = due;
    for (int i = 0; i < 6; i++) begin
      int code = 0, pts;
      bit ok = 0;
      for (int j = 0; j < 14; j++) if (h[i] == tbl[j]) begin code = j; ok = 1; end
      x.card[i*4 +: 4] = code[3:0];
      pts = (code >= 1 && code <= 9) ? code : 0;
      if (i < 3) ps += pts; else ds += pts;
      if (!ok && !x.e) begin x.e = 1; x.ed = i[2:0]; end
    end
    ps = ps % 10;
    ds = ds % 10;
    x.ps = ps[3:0];
    x.ds = ds[3:0];
    return x;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t x;
    if (resetb && valid) begin
      vcount++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid=1 expected no valid");
      end else begin
        x = q.pop_front();
        chk("latency_cycle", cyc, int'(x.due));
        chk("busy_at_valid", busy, 0);
        chk("pcard1", pcard1, x.card[3:0]);
        chk("pcard2", pcard2, x.card[7:4]);
        chk("pcard3", pcard3, x.card[11:8]);
        chk("dcard1", dcard1, x.card[15:12]);
        chk("dcard2", dcard2, x.card[19:16]);
        chk("dcard3", dcard3, x.card[23:20]);
        chk("pscore", pscore, x.ps);
        chk("dscore", dscore, x.ds);
        chk("err", err, x.e);
        chk("err_digit", err_digit, x.ed);
      end
    end
  end

  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 20) begin @(negedge clk); n++; end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: got no valid in 20 cycles expected valid");
      q.delete();
    end
  endtask

  // scrambling HEX right after acceptance proves the scan works from the snapshot
  task automatic scan(input logic [6:0] h [6]);
    @(negedge clk);
    hex = h;
    start = 1'b1;
    q.push_back(model(h, cyc + 8));
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < 6; i++) hex[i] = 7'($urandom);
    wait_done();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [6:0] h [6];
    int v0;
    logic [6:0] b, a;
    b = tbl[0];
    a = tbl[1];
    hex = '{default: 7'b1111111};
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_pcard1", pcard1, 0);
    chk("rst_dcard3", dcard3, 0);
    chk("rst_pscore", pscore, 0);
    chk("rst_err", err, 0);
    chk("rst_err_digit", err_digit, 0);
    resetb = 1'b1;
    h = '{b, b, b, b, b, b};                         scan(h);
    h = '{a, b, b, tbl[4], b, b};                    scan(h);
    h = '{a, tbl[8], b, a, tbl[13], b};              scan(h);
    h = '{a, a, a, a, a, a};                         scan(h);
    h = '{tbl[9], tbl[9], tbl[9], tbl[10], tbl[10], tbl[10]}; scan(h);
    h = '{b, b, 7'b0101010, b, b, 7'b1010101};       scan(h);
    h = '{tbl[2], tbl[3], tbl[5], tbl[6], tbl[7], tbl[12]}; scan(h);
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 6; i++)
        h[i] = ($urandom_range(0, 4) == 0) ? 7'($urandom) : tbl[$urandom_range(0, 13)];
      scan(h);
    end
    // a start pulse two cycles into a scan must be dropped, not queued
    v0 = vcount;
    h = '{a, tbl[2], b, tbl[3], b, b};
    @(negedge clk);
    hex = h;
    start = 1'b1;
    q.push_back(model(h, cyc + 8));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (12) @(negedge clk);
    chk("single_valid", vcount - v0, 1);
    // asynchronous reset in the middle of a scan
    h = '{a, a, a, a, a, a};
    @(negedge clk);
    hex = h;
    start = 1'b1;
    q.push_back(model(h, cyc + 8));
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pcard1_mid_scan", pcard1, 1);
    @(posedge clk);
    #2 resetb = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_pcard1", pcard1, 0);
    chk("midrst_pcard2", pcard2, 0);
    chk("midrst_pscore", pscore, 0);
    q.delete();
    v0 = vcount;
    repeat (3) @(negedge clk);
    resetb = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_no_valid", vcount - v0, 0);
    chk("midrst_idle_busy", busy, 0);
    h = '{tbl[8], b, b, b, tbl[9], b};               scan(h);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
